// File: rtl/tiny_mips_cpu.sv
// tiny_mips_cpu: 16-bit multi-cycle load/store CPU, 8 registers, one synchronous RAM port.
// Define TINYMIPS_MUL_EN to turn opcode 1101 into MUL; otherwise it executes as a NOP.
module tiny_mips_cpu #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     data_fromRAM,
    output logic            wrEn,
    output logic [SIZE-1:0] addr_toRAM,
    output logic [15:0]     data_toRAM
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, LOADWB, HALT} state_t;

    state_t          r_state, w_next;
    logic [SIZE-1:0] r_pc, w_pc_next, w_pc_inc, w_pc_br, w_ea;
    logic [15:0]     r_ir;
    logic [15:0]     r_regs [8];
    logic [3:0]      w_op;
    logic [2:0]      w_a;
    logic [15:0]     w_ra, w_rb, w_rc, w_simm, w_alu;
    logic            w_we, w_mem, w_st;

    assign w_op     = r_ir[15:12];
    assign w_a      = r_ir[11:9];
    assign w_ra     = r_regs[r_ir[11:9]];
    assign w_rb     = r_regs[r_ir[8:6]];
    assign w_rc     = r_regs[r_ir[5:3]];
    assign w_simm   = {{10{r_ir[5]}}, r_ir[5:0]};
    assign w_pc_inc = r_pc + SIZE'(1);
    assign w_pc_br  = r_pc + w_simm[SIZE-1:0];
    assign w_ea     = w_rb[SIZE-1:0] + w_simm[SIZE-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_regs  <= '{default: '0};
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) r_ir <= data_fromRAM;
            // R0 is never written, so it keeps its reset value of zero
            if (r_state == EXEC && w_we && w_a != 3'd0) r_regs[w_a] <= w_alu;
            if (r_state == LOADWB && w_a != 3'd0) r_regs[w_a] <= data_fromRAM;
            if (r_state == LOADWB) r_pc <= w_pc_inc;
            else if (r_state == EXEC && w_op != 4'hA && w_op != 4'hF) r_pc <= w_pc_next;
        end
    end

    always_comb begin
        w_next = r_state == FETCH  ? DECODE :
                 r_state == DECODE ? EXEC :
                 r_state == EXEC   ? (w_op == 4'hA ? LOADWB : w_op == 4'hF ? HALT : FETCH) :
                 r_state == HALT   ? HALT : FETCH;
    end

    always_comb begin
        w_alu     = '0;
        w_we      = 1'b1;
        w_pc_next = w_pc_inc;
        case (w_op)
            4'h0: w_alu = w_rb + w_rc;
            4'h1: w_alu = w_rb + w_simm;
            4'h2: w_alu = ~(w_rb & w_rc);
            4'h3: w_alu = ~(w_rb & w_simm);
            4'h4: w_alu = w_rb >> w_rc[3:0];
            4'h5: w_alu = w_rb << w_rc[3:0];
            4'h6: w_alu = {15'd0, w_rb < w_rc};
            4'h7: w_alu = {7'd0, r_ir[8:0]};
            4'h8: begin
                w_we      = 1'b0;
                w_pc_next = (w_ra == w_rb) ? w_pc_br : w_pc_inc;
            end
            4'h9: begin
                w_we      = 1'b0;
                w_pc_next = (w_ra < w_rb) ? w_pc_br : w_pc_inc;
            end
            4'hC: begin
                w_alu     = 16'(w_pc_inc);
                w_pc_next = w_rb[SIZE-1:0];
            end
            4'hD: begin
`ifdef TINYMIPS_MUL_EN
                w_alu = w_rb * w_rc;
`else
                w_we  = 1'b0;
`endif
            end
            4'hE: w_alu = w_rb;
            default: w_we = 1'b0;
        endcase
    end

    // Outputs are forced quiet during reset so an aborted store never reaches the RAM
    always_comb begin
        w_mem      = r_state == EXEC && (w_op == 4'hA || w_op == 4'hB);
        w_st       = !rst && r_state == EXEC && w_op == 4'hB;
        wrEn       = w_st;
        addr_toRAM = rst ? '0 : w_mem ? w_ea : r_pc;
        data_toRAM = w_st ? w_ra : '0;
    end
endmodule

// File: tb/tb_tiny_mips_cpu.sv
// tb_tiny_mips_cpu: ISA-level reference model predicts every RAM write and its cycle;
// a monitor process checks writes, reset outputs and halt behaviour against the queue.
module tb_tiny_mips_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_fromRAM;
    logic        wrEn;
    logic [7:0]  addr_toRAM;
    logic [15:0] data_toRAM;

    tiny_mips_cpu #(.SIZE(8)) dut (
        .clk(clk), .rst(rst), .data_fromRAM(data_fromRAM),
        .wrEn(wrEn), .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        int          t;
    } wr_t;

    logic [15:0] ram [256];
    logic [15:0] img [256];
    logic [15:0] pimg [256];
    logic        load = 1'b0;
    int          cyc;
    wr_t         q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        end_chk = 1'b0;
    logic        halt_win = 1'b0;

    always @(posedge clk) begin
        if (load) ram <= img;
        else if (wrEn) ram[addr_toRAM] <= data_toRAM;
        data_fromRAM <= ram[addr_toRAM];
    end

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin
        wr_t        e;
        logic [7:0] last_addr;
        bit         have_last;
        have_last = 0;
        last_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_cmp++;
                if (wrEn !== 1'b0 || addr_toRAM !== 8'd0 || data_toRAM !== 16'd0) begin
                    n_bad++;
                    $display("FAIL reset_outputs: wrEn=%b addr=%0d data=%h, required 0 0 0000",
                             wrEn, addr_toRAM, data_toRAM);
                end
            end else if (wrEn) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: addr=%0d data=%h cycle=%0d, required no write",
                             addr_toRAM, data_toRAM, cyc);
                end else begin
                    e = q.pop_front();
                    if (addr_toRAM !== e.a || data_toRAM !== e.d || cyc != e.t) begin
                        n_bad++;
                        $display("FAIL store: addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                                 addr_toRAM, data_toRAM, cyc, e.a, e.d, e.t);
                    end
                end
            end
            if (halt_win) begin
                if (have_last) begin
                    n_cmp++;
                    if (addr_toRAM !== last_addr || wrEn !== 1'b0) begin
                        n_bad++;
                        $display("FAIL halt_frozen: addr=%0d wrEn=%b, required addr=%0d wrEn=0",
                                 addr_toRAM, wrEn, last_addr);
                    end
                end
                last_addr = addr_toRAM;
                have_last = 1;
            end else have_last = 0;
            if (end_chk) begin
                n_cmp++;
                if (q.size() != 0) begin
                    n_bad++;
                    $display("FAIL missing_writes: %0d outstanding, required 0", q.size());
                    q.delete();
                end
            end
        end
    end

    function automatic logic [15:0] enc(int op, int a, int b, logic [5:0] l);
        logic [3:0] o = op[3:0];
        logic [2:0] ra = a[2:0];
        logic [2:0] rb = b[2:0];
        return {o, ra, rb, l};
    endfunction

    function automatic logic [15:0] enci(int a, int imm);
        logic [2:0] ra = a[2:0];
        logic [8:0] i9 = imm[8:0];
        return {4'h7, ra, i9};
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 256; i++) pimg[i] = 16'($urandom);
    endtask

    task automatic put(int a, logic [15:0] w);
        pimg[a] = w;
    endtask

    // Store R1..R7 to 249..255 so the register file becomes visible on the RAM port, then halt
    task automatic dump(int p);
        for (int i = 1; i < 8; i++) put(p + i - 1, enc(11, i, 0, 6'(56 + i)));
        put(p + 7, 16'hF000);
    endtask

    // Instruction-level interpreter: one loop iteration per instruction, 3 cycles each, LD 4
    task automatic iss(output int tend);
        logic [15:0] m [256];
        logic [15:0] r [8];
        logic [7:0]  pc, npc, ea;
        logic [15:0] ir, ra, rb, rc, sx, res;
        logic [2:0]  a;
        bit          wr;
        int          t;
        m = pimg;
        r = '{default: '0};
        pc = 0;
        t = 0;
        tend = 0;
        for (int s = 0; s < 5000; s++) begin
            ir  = m[pc];
            a   = ir[11:9];
            ra  = r[ir[11:9]];
            rb  = r[ir[8:6]];
            rc  = r[ir[5:3]];
            sx  = {{10{ir[5]}}, ir[5:0]};
            ea  = rb[7:0] + sx[7:0];
            npc = pc + 8'd1;
            wr  = 1;
            res = '0;
            case (ir[15:12])
                4'h0: res = rb + rc;
                4'h1: res = rb + sx;
                4'h2: res = ~(rb & rc);
                4'h3: res = ~(rb & sx);
                4'h4: res = rb >> rc[3:0];
                4'h5: res = rb << rc[3:0];
                4'h6: res = (rb < rc) ? 16'd1 : 16'd0;
                4'h7: res = {7'd0, ir[8:0]};
                4'h8: begin wr = 0; if (ra == rb) npc = pc + sx[7:0]; end
                4'h9: begin wr = 0; if (ra < rb) npc = pc + sx[7:0]; end
                4'hA: begin res = m[ea]; t++; end
                4'hB: begin wr = 0; m[ea] = ra; q.push_back('{ea, ra, t + 2}); end
                4'hC: begin res = {8'd0, pc + 8'd1}; npc = rb[7:0]; end
`ifdef TINYMIPS_MUL_EN
                4'hD: res = rb * rc;
`else
                4'hD: wr = 0;
`endif
                4'hE: res = rb;
                default: begin tend = t + 2; return; end
            endcase
            if (wr && a != 3'd0) r[a] = res;
            pc = npc;
            t += 3;
        end
        tend = t;
    endtask

    task automatic run_prog();
        int tend;
        iss(tend);
        img = pimg;
        #1 load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        repeat (tend + 3) @(posedge clk);
        #1 halt_win = 1'b1;
        repeat (6) @(posedge clk);
        #1 halt_win = 1'b0;
        end_chk = 1'b1;
        @(posedge clk);
        #1 end_chk = 1'b0;
        rst = 1'b1;
    endtask

    task automatic gen_random();
        int op, a, b;
        logic [5:0] l;
        clear_img();
        for (int i = 0; i < 20; i++) begin
            op = $urandom_range(0, 14);
            a  = $urandom_range(0, 7);
            b  = $urandom_range(0, 7);
            l  = 6'($urandom);
            if (op == 12) op = 0;
            if (op == 8 || op == 9) l = 6'($urandom_range(1, 4));
            if (op == 11) begin b = 0; l = 6'($urandom_range(32, 63)); end
            put(i, enc(op, a, b, l));
        end
        dump(20);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        // sum 1..5 loop with backward BLT
        clear_img();
        put(0, 16'h7201); put(1, 16'h7400); put(2, 16'h7606);
        put(3, 16'h0488); put(4, 16'h1241); put(5, 16'h92FE);
        dump(6);
        run_prog();
        // CPi / ADDi negative immediate / NAND
        clear_img();
        put(0, enci(1, 'h1FF)); put(1, enc(1, 2, 1, 6'h3F)); put(2, enc(2, 3, 1, {3'd2, 3'd0}));
        dump(3);
        run_prog();
        // store then load back through memory
        clear_img();
        put(0, enci(1, 'h55)); put(1, enc(11, 1, 0, 6'd20)); put(2, enc(10, 4, 0, 6'd20));
        dump(3);
        run_prog();
        // BEQ taken and not taken, JAL to 40
        clear_img();
        put(0, enci(5, 40)); put(1, enci(1, 3)); put(2, enc(8, 1, 1, 6'd2)); put(3, enci(2, 9));
        put(4, enc(8, 1, 0, 6'd2)); put(5, enci(3, 4)); put(6, enc(12, 7, 5, 6'd0));
        dump(40);
        run_prog();
        // R0 stays zero; MUL or NOP depending on build
        clear_img();
        put(0, enci(4, 9)); put(1, enci(0, 7)); put(2, enc(0, 4, 0, 6'd0));
        put(3, enci(1, 300)); put(4, enci(2, 300)); put(5, enci(3, 'h77));
        put(6, enc(13, 3, 1, {3'd2, 3'd0}));
        dump(7);
        run_prog();
        // PC wraps from 255 to 0
        clear_img();
        put(0, enc(8, 4, 0, 6'd3)); put(1, enc(8, 0, 0, 6'd9));
        put(3, enci(5, 'hFE)); put(4, enc(12, 6, 5, 6'd0));
        put(254, enc(1, 4, 0, 6'd5)); put(255, enc(1, 2, 2, 6'd1));
        dump(10);
        run_prog();
        // reset asserted during the store's execute cycle must suppress the write
        clear_img();
        put(0, enci(1, 'h55)); put(1, enc(11, 1, 0, 6'h3F)); put(2, 16'hF000);
        img = pimg;
        #1 load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            gen_random();
            run_prog();
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
